// File: rtl/mips_pkg.sv
// Shared MIPS-32 definitions: opcode constants, fetch FSM states, reset PC,
// and the branch-offset helper used by next-PC generation.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  // Word offset of a branch immediate as a 32-bit byte displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next program counter: jump beats taken branch beats sequential.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  // The opcode field is decoded by the control unit, not here.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[31:26];

  // NOTE: assign a default before the if-chain so no path leaves next_pc unassigned (no latch).
  always_comb begin
    next_pc = pc_plus4;
    if (Jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (Branch && Zero)
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS-32 instruction fetch: PC owner, single-outstanding imem req/rvalid, retire on instr_ready.
// Define FETCH_PERF_CNT_EN to add the perf_retired / perf_stall counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] instr,
  output logic [5:0]  OPcode,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e state;
  logic [31:0]  next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign OPcode    = instr[31:26];
  assign Funct     = instr[5:0];

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr),
    .Branch   (Branch),
    .Jump     (Jump),
    .Zero     (Zero),
    .next_pc  (next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          // The cycle after reset raises the request; rvalid only counts once it is up.
          imem_req <= 1'b1;
          if (imem_req && imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // A stall is a cycle spent waiting on memory with the request raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (state == VALID && instr_ready)
        perf_retired <= perf_retired + 32'd1;
      if (state == FETCH && imem_req && !imem_rvalid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
